// File: rtl/rv32ima_pkg.sv
// Shared types for the sequential divider: operation and FSM state
// encodings, the common operand width, and small op-decoding helpers.
package rv32ima_pkg;

  localparam int BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_t;

  // True for the two's-complement operations (DIV, REM).
  function automatic logic op_is_signed(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // True when the remainder, not the quotient, is the result.
  function automatic logic op_is_rem(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration, purely combinational.
// quo_i carries the not-yet-consumed dividend bits at the top and the
// quotient bits produced so far at the bottom; each step consumes the
// dividend MSB and shifts one quotient bit in at the LSB.
module div_step
  import rv32ima_pkg::*;
#(
  parameter int WIDTH = BIT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, div_i};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_o = diff_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU with valid/ready
// handshakes on request and response, plus flush.
// Optional feature macro: DIV_SEQ_EARLY_OUT_EN -- when defined, divide-by-
// zero and signed overflow are resolved in PREP and jump straight to DONE.
module div_seq
  import rv32ima_pkg::*;
#(
  parameter int WIDTH = BIT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  input  logic             flush,
  output logic             busy
);

  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  div_state_t       state_q, state_d, state_nx_s;
  div_op_t          op_q, op_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend in, quotient out
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor (magnitude after PREP)
  logic [WIDTH-1:0] res_q, res_d;   // response register
  logic [4:0]       cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic             b_zero_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
`ifdef DIV_SEQ_EARLY_OUT_EN
  logic             ovf_s;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state and datapath computation for every FSM state.
  always_comb begin
    state_nx_s = state_q;
    op_d       = op_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;

    a_neg_s  = op_is_signed(op_q) & quo_q[WIDTH-1];
    b_neg_s  = op_is_signed(op_q) & dvs_q[WIDTH-1];
    b_zero_s = (dvs_q == {WIDTH{1'b0}});
    q_fix_s  = q_neg_q ? (-quo_q) : quo_q;
    r_fix_s  = r_neg_q ? (-rem_q) : rem_q;
`ifdef DIV_SEQ_EARLY_OUT_EN
    ovf_s    = op_is_signed(op_q)
             & (quo_q == {1'b1, {(WIDTH-1){1'b0}}})
             & (dvs_q == {WIDTH{1'b1}});
`endif

    case (state_q)
      ST_IDLE: begin
        // Latching is gated by flush so a flushed request leaves no trace.
        if (req_valid && !flush) begin
          op_d       = div_op_t'(req_op);
          quo_d      = req_a;
          dvs_d      = req_b;
          state_nx_s = ST_PREP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PREP: begin
        quo_d   = a_neg_s ? (-quo_q) : quo_q;
        dvs_d   = b_neg_s ? (-dvs_q) : dvs_q;
        rem_d   = {WIDTH{1'b0}};
        // A zero divisor yields an all-ones magnitude quotient, which must
        // stay all ones, so its sign is never applied.
        q_neg_d = (a_neg_s ^ b_neg_s) & ~b_zero_s;
        r_neg_d = a_neg_s;
        cnt_d   = CNT_LAST;
        state_nx_s = ST_CALC;
`ifdef DIV_SEQ_EARLY_OUT_EN
        if (b_zero_s) begin
          res_d      = op_is_rem(op_q) ? quo_q : {WIDTH{1'b1}};
          state_nx_s = ST_DONE;
        end else if (ovf_s) begin
          res_d      = op_is_rem(op_q) ? {WIDTH{1'b0}} : quo_q;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CALC;
        end
`endif
      end
      ST_CALC: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (cnt_q == 5'd0) begin
          state_nx_s = ST_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FIX: begin
        res_d      = op_is_rem(op_q) ? r_fix_s : q_fix_s;
        state_nx_s = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // Flush wins over any transition, including a DONE handshake.
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_nx_s;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DIV;
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      cnt_q   <= 5'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    resp_data  = res_q;
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq. Latency is counted in rising
// edges with the accepting edge as edge 1, so the normal path gives 35 and
// the early-out path gives 2.
module tb_div_seq;
  import rv32ima_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        flush;
  logic        busy;

  int checks;
  int failures;
  int sp_lat;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .flush      (flush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, wait for the response, return data and latency,
  // then complete the handshake. lat = -1 marks a timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic do_ack,
                        output logic [31:0] data, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) lat = -1;
    data = resp_data;
    if (do_ack) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset: ready/valid/busy=%b data=%h, want 100 data=0",
               {req_ready, resp_valid, busy}, resp_data);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, d, lat);
    checks++;
    if (d !== 32'd14) begin failures++; $display("FAIL divu_100_7: got %h want %h", d, 32'd14); end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL divu_latency: got %0d want 35", lat); end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_ack: ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_signed();
    logic [31:0] d;
    int lat;
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2: got %h want ffffffff", d); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2: got %h want fffffffd", d); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2: got %h want fffffffd", d); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 1'b1, d, lat);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL rem_7_m2: got %h want 1", d); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b1, d, lat);
    checks++;
    if (d !== 32'h0FFF_FFFF) begin failures++; $display("FAIL divu_max_16: got %h want 0fffffff", d); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd16, 1'b1, d, lat);
    checks++;
    if (d !== 32'd15) begin failures++; $display("FAIL remu_max_16: got %h want f", d); end
  endtask

  task automatic test_special();
    logic [31:0] d;
    int lat;
    run_op(OP_DIV, 32'd5, 32'd0, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_5_0: got %h want ffffffff", d); end
    checks++;
    if (lat !== sp_lat) begin failures++; $display("FAIL div0_latency: got %0d want %0d", lat, sp_lat); end
    run_op(OP_REMU, 32'd5, 32'd0, 1'b1, d, lat);
    checks++;
    if (d !== 32'd5) begin failures++; $display("FAIL remu_5_0: got %h want 5", d); end
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_m5_0: got %h want ffffffff", d); end
    run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFB) begin failures++; $display("FAIL rem_m5_0: got %h want fffffffb", d); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, d, lat);
    checks++;
    if (d !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf: got %h want 80000000", d); end
    checks++;
    if (lat !== sp_lat) begin failures++; $display("FAIL ovf_latency: got %0d want %0d", lat, sp_lat); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, d, lat);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rem_ovf: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int lat;
    int bad;
    run_op(OP_DIVU, 32'd1000, 32'd10, 1'b0, d, lat);
    checks++;
    if (d !== 32'd100) begin failures++; $display("FAIL bp_result: got %h want 64", d); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_data !== 32'd100 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d bad cycles, valid=%b data=%h ready=%b want 1 64 0",
               bad, resp_valid, resp_data, req_ready);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL bp_release: ready/valid/busy=%b want 100", {req_ready, resp_valid, busy});
    end
    req_valid = 1'b1; req_op = OP_REMU; req_a = 32'd1003; req_b = 32'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: busy=%b ready=%b want 1 0", busy, req_ready);
    end
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (!resp_valid || resp_data !== 32'd3) begin
      failures++; $display("FAIL b2b_result: valid=%b data=%h want 1 3", resp_valid, resp_data);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int lat;
    int seen;
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clk); #1;               // accepted: PREP
    req_valid = 1'b0;
    repeat (10) @(posedge clk);       // CALC cycle 10
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL flush_idle: ready/valid/busy=%b want 100", {req_ready, resp_valid, busy});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_resp: valid seen %0d cycles want 0", seen); end
    run_op(OP_DIVU, 32'd1000, 32'd3, 1'b1, d, lat);
    checks++;
    if (d !== 32'd333) begin failures++; $display("FAIL after_flush: got %h want 14d", d); end
  endtask

  task automatic test_rst_flush();
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd77; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_calc: ready/valid/busy=%b data=%h want 100 data=0",
               {req_ready, resp_valid, busy}, resp_data);
    end
  endtask

  initial begin
`ifdef DIV_SEQ_EARLY_OUT_EN
    sp_lat = 2;
`else
    sp_lat = 35;
`endif
    checks = 0; failures = 0;
    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
    resp_ready = 1'b0; flush = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_back_to_back();
    test_flush();
    test_rst_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default BIT_WIDTH (32), operand/result width; only 32 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  unit can accept; high only in IDLE.
REQ-006 req_op  input  2  div_op_t: DIV, DIVU, REM, REMU.
REQ-007 req_a  input  WIDTH  dividend.
REQ-008 req_b  input  WIDTH  divisor.
REQ-009 resp_valid  output  1  result available; high only in DONE.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_data  output  WIDTH  quotient or remainder per latched op.
REQ-012 flush  input  1  abandon any operation in progress.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Accept on req_valid & req_ready; latch op, a, b on that edge; inputs are ignored otherwise.
REQ-015 States IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE; no other transitions except via flush or rst.
REQ-016 PREP, 1 cycle: signed ops take magnitudes of a and b and record quotient sign (a_msb ^ b_msb) and remainder sign (a_msb); unsigned ops use raw values.
REQ-017 CALC, exactly WIDTH cycles: one restoring radix-2 step per cycle (shift remainder left by one, bring in the dividend MSB, trial-subtract the divisor magnitude on WIDTH+1 bits, keep the result if non-negative, shift the quotient bit in); a 5-bit counter counts down from 31 and exits at 0.
REQ-018 FIX, 1 cycle: negate quotient/remainder per recorded signs for signed ops; select quotient (DIV/DIVU) or remainder (REM/REMU) into the output register.
REQ-019 DONE: resp_valid=1 and resp_data stable until resp_ready; on resp_valid & resp_ready go to IDLE; req_ready stays 0 in DONE, so back-to-back acceptance occurs no earlier than the cycle after the handshake.
REQ-020 Normal latency: resp_valid rises 35 rising edges after the accepting edge.
REQ-021 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> req_a.
REQ-022 Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
REQ-023 flush in any state forces IDLE on the next edge, deasserts resp_valid, and never produces a response; flush takes priority over a simultaneous request or handshake.
REQ-024 resp_data is a registered output; there is no combinational path from req_* to resp_*.

Reset
REQ-025 On rst: state=IDLE, counter=0, resp_data=0, resp_valid=0, busy=0, req_ready=1 from the next cycle; rst overrides flush and any operation in progress.

Configuration
REQ-026 Macro DIV_SEQ_EARLY_OUT_EN: when defined, divide-by-zero and signed overflow are detected in PREP and the FSM goes PREP -> DONE, so resp_valid rises 2 edges after acceptance; when undefined, these cases traverse CALC and FIX with the full 35-edge latency. Result values are identical in both builds.

Structure
REQ-027 The div_op_t enum and div_state_t enum belong in rv32ima_pkg, with BIT_WIDTH reused from there.
REQ-028 One combinational sub-module, div_step, implements a single restoring iteration (remainder, quotient, and divisor in; next remainder and quotient out); div_seq instantiates it once.

Verification
REQ-029 DIVU a=100, b=7 -> resp_data=14, resp_valid rises exactly 35 edges after acceptance.
REQ-030 REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-031 DIV a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; check latency is 2 with DIV_SEQ_EARLY_OUT_EN and 35 without.
REQ-032 Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data held, req_ready=0; release -> IDLE next edge, a new request is accepted the following cycle.
REQ-033 Assert flush at CALC cycle 10 -> IDLE next edge, busy=0, no resp_valid; the next request returns a correct result.
REQ-034 Assert rst mid-CALC together with flush -> all outputs at their reset values on the next edge.
